// File: rtl/conv3x3_pkg.sv
// rtl/conv3x3_pkg.sv - shared FSM state, default kernel and width helpers for conv3x3_filter
package conv3x3_pkg;

  localparam int NTAPS = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_NORM,
    S_OUT
  } state_t;

  // Gaussian smoothing kernel; pair with a shift of 4
  localparam int DEF_KERNEL [NTAPS] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

  function automatic int acc_w(input int data_w, input int coef_w);
    return data_w + coef_w + 5;
  endfunction

endpackage

// File: rtl/conv3x3_norm.sv
// rtl/conv3x3_norm.sv - combinational normalise and clamp; CONV3X3_ROUND_EN selects round-half-up
module conv3x3_norm
  import conv3x3_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = 4,
  parameter int ACC_W   = 17
) (
  input  logic signed [ACC_W-1:0]   i_acc,
  input  logic        [SHIFT_W-1:0] i_shift,
  output logic        [DATA_W-1:0]  o_data
);

  logic signed [ACC_W-1:0] w_bias;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_shifted;

  always_comb begin
    w_bias = '0;
`ifdef CONV3X3_ROUND_EN
    if (i_shift != '0) begin
      w_bias = {{(ACC_W-1){1'b0}}, 1'b1} << (i_shift - SHIFT_W'(1));
    end
`endif
    w_sum     = i_acc + w_bias;
    w_shifted = w_sum >>> i_shift;
    // Negative saturates to 0, anything above the pixel range to all-ones
    if (w_shifted[ACC_W-1]) begin
      o_data = '0;
    end else if (|w_shifted[ACC_W-2:DATA_W]) begin
      o_data = '1;
    end else begin
      o_data = w_shifted[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/conv3x3_filter.sv
// rtl/conv3x3_filter.sv - 3x3 sequential-MAC convolution with programmable kernel (option: CONV3X3_ROUND_EN)
module conv3x3_filter
  import conv3x3_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 4,
  parameter int SHIFT_W = 4
) (
  input  logic                      clk_i_g,
  input  logic                      rst_i_g,
  input  logic                      en_i_g,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [NTAPS*DATA_W-1:0]   win_i,
  input  logic [SHIFT_W-1:0]        shift_i,
  input  logic                      coef_we_i,
  input  logic [3:0]                coef_addr_i,
  input  logic [COEF_W-1:0]         coef_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_W-1:0]         data_o,
  output logic                      busy_o
);

  localparam int ACC_W = acc_w(DATA_W, COEF_W);

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_armed;
  logic [NTAPS*DATA_W-1:0]  r_win;
  logic [SHIFT_W-1:0]       r_shift;
  logic signed [ACC_W-1:0]  r_acc;
  logic [3:0]               r_idx;
  logic signed [COEF_W-1:0] r_coef [NTAPS];
  logic signed [COEF_W-1:0] r_kern [NTAPS];
  logic [DATA_W-1:0]        r_data;
  logic                     r_out_valid;

  logic                     w_accept;
  logic                     w_coef_wr;
  logic [DATA_W-1:0]        w_pix;
  logic signed [COEF_W-1:0] w_coef;
  logic signed [ACC_W-1:0]  w_pix_ext;
  logic signed [ACC_W-1:0]  w_coef_ext;
  logic signed [ACC_W-1:0]  w_prod;
  logic [DATA_W-1:0]        w_norm;

  assign in_ready_o  = (r_state == S_IDLE) && en_i_g && r_armed;
  assign busy_o      = (r_state != S_IDLE);
  assign out_valid_o = r_out_valid;
  assign data_o      = r_data;
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_coef_wr   = coef_we_i && (r_state == S_IDLE) && (coef_addr_i < 4'(NTAPS));

  always_ff @(posedge clk_i_g or negedge rst_i_g) begin
    if (!rst_i_g) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!en_i_g) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_next = S_MAC;
        S_MAC:   if (r_idx == 4'(NTAPS-1)) w_next = S_NORM;
        S_NORM:  w_next = S_OUT;
        S_OUT:   if (out_ready_i) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_pix  = '0;
    w_coef = '0;
    for (int k = 0; k < NTAPS; k++) begin
      if (r_idx == 4'(k)) begin
        w_pix  = r_win[k*DATA_W +: DATA_W];
        w_coef = r_kern[k];
      end
    end
  end

  assign w_coef_ext = {{(ACC_W-COEF_W){w_coef[COEF_W-1]}}, w_coef};
  assign w_pix_ext  = {{(ACC_W-DATA_W){1'b0}}, w_pix};
  assign w_prod     = w_coef_ext * w_pix_ext;

  conv3x3_norm #(
    .DATA_W  (DATA_W),
    .SHIFT_W (SHIFT_W),
    .ACC_W   (ACC_W)
  ) u_norm (
    .i_acc   (r_acc),
    .i_shift (r_shift),
    .o_data  (w_norm)
  );

  // The kernel is snapshotted at accept so a same-edge coefficient write only affects later windows
  always_ff @(posedge clk_i_g or negedge rst_i_g) begin
    if (!rst_i_g) begin
      r_armed     <= 1'b0;
      r_win       <= '0;
      r_shift     <= '0;
      r_acc       <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        r_coef[k] <= COEF_W'(DEF_KERNEL[k]);
        r_kern[k] <= '0;
      end
    end else begin
      if (en_i_g) r_armed <= 1'b1;
      if (w_coef_wr) begin
        for (int k = 0; k < NTAPS; k++) begin
          if (coef_addr_i == 4'(k)) r_coef[k] <= coef_data_i;
        end
      end
      if (!en_i_g) begin
        r_acc       <= '0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_win   <= win_i;
              r_shift <= shift_i;
              r_acc   <= '0;
              r_idx   <= '0;
              for (int k = 0; k < NTAPS; k++) r_kern[k] <= r_coef[k];
            end
          end
          S_MAC: begin
            r_acc <= r_acc + w_prod;
            r_idx <= r_idx + 4'd1;
          end
          S_NORM: begin
            r_data      <= w_norm;
            r_out_valid <= 1'b1;
          end
          S_OUT: begin
            if (out_ready_i) r_out_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_filter.sv
// tb/tb_conv3x3_filter.sv - scoreboard bench for conv3x3_filter (expectations follow CONV3X3_ROUND_EN)
module tb_conv3x3_filter;

  localparam int DATA_W  = 8;
  localparam int COEF_W  = 4;
  localparam int SHIFT_W = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 en = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [9*DATA_W-1:0]  win = '0;
  logic [SHIFT_W-1:0]   shift = '0;
  logic                 coef_we = 1'b0;
  logic [3:0]           coef_addr = '0;
  logic [COEF_W-1:0]    coef_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [DATA_W-1:0]    data;
  logic                 busy;

  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;
  int accept_cycle = 0;
  logic [DATA_W-1:0] exp_q[$];

  conv3x3_filter #(.DATA_W(DATA_W), .COEF_W(COEF_W), .SHIFT_W(SHIFT_W)) dut (
    .clk_i_g     (clk),
    .rst_i_g     (rst_n),
    .en_i_g      (en),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .win_i       (win),
    .shift_i     (shift),
    .coef_we_i   (coef_we),
    .coef_addr_i (coef_addr),
    .coef_data_i (coef_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .data_o      (data),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  // Monitor: every completed output handshake is compared with the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %0d, expected no output", data);
      end else begin
        check("result", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  function automatic logic [9*DATA_W-1:0] fill(input logic [7:0] centre, input logic [7:0] other);
    logic [9*DATA_W-1:0] w;
    for (int k = 0; k < 9; k++) w[k*DATA_W +: DATA_W] = (k == 4) ? centre : other;
    return w;
  endfunction

  task automatic send(input logic [9*DATA_W-1:0] w, input logic [SHIFT_W-1:0] sh);
    int t;
    t = 0;
    win = w;
    shift = sh;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 100) begin
        timeout("accept");
        break;
      end
    end
    @(posedge clk);
    #1;
    accept_cycle = cycle;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) break;
      t++;
      if (t > 100) begin
        timeout("out_valid");
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!busy && !out_valid) break;
      t++;
      if (t > 100) begin
        timeout("idle");
        break;
      end
    end
  endtask

  task automatic write_coef(input logic [3:0] addr, input logic [COEF_W-1:0] val);
    coef_we = 1'b1;
    coef_addr = addr;
    coef_data = val;
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  initial begin
    logic [7:0] lap [9];
    lap = '{8'd0, 8'hFF, 8'd0, 8'hFF, 8'd4, 8'hFF, 8'd0, 8'hFF, 8'd0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready}, 0);
    check("reset_out_valid", {31'd0, out_valid}, 0);
    check("reset_data", {24'd0, data}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    en = 1'b1;

    // Gaussian, flat 100, shift 4 -> 100 with 10-cycle latency
    exp_q.push_back(8'd100);
    send(fill(8'd100, 8'd100), 4'd4);
    wait_valid();
    check("latency", cycle - accept_cycle, 10);
    wait_idle();

    // Centre 255 alone: 1020/16 = 63.75
`ifdef CONV3X3_ROUND_EN
    exp_q.push_back(8'd64);
`else
    exp_q.push_back(8'd63);
`endif
    send(fill(8'd255, 8'd0), 4'd4);
    wait_idle();

    // Downstream stall: output held, no new accept
    out_ready = 1'b0;
    exp_q.push_back(8'd50);
    send(fill(8'd50, 8'd50), 4'd4);
    wait_valid();
    win = fill(8'd1, 8'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_data", {24'd0, data}, 50);
      check("stall_in_ready", {31'd0, in_ready}, 0);
      check("stall_valid", {31'd0, out_valid}, 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_busy", {31'd0, busy}, 0);
    check("release_valid", {31'd0, out_valid}, 0);

    // Write during MAC is dropped: both windows use centre weight 4 (16*10)
    exp_q.push_back(8'd160);
    send(fill(8'd10, 8'd10), 4'd0);
    coef_we = 1'b1;
    coef_addr = 4'd4;
    coef_data = 4'd7;
    repeat (3) @(posedge clk);
    #1;
    coef_we = 1'b0;
    wait_idle();
    exp_q.push_back(8'd160);
    send(fill(8'd10, 8'd10), 4'd0);
    wait_idle();

    // Write coincident with accept lands, but only the following window sees 7 (19*10)
    exp_q.push_back(8'd160);
    coef_we = 1'b1;
    coef_addr = 4'd4;
    coef_data = 4'd7;
    send(fill(8'd10, 8'd10), 4'd0);
    coef_we = 1'b0;
    wait_idle();
    exp_q.push_back(8'd190);
    send(fill(8'd10, 8'd10), 4'd0);
    wait_idle();

    // Laplacian: clamp low and clamp high
    for (int k = 0; k < 9; k++) write_coef(4'(k), lap[k][3:0]);
    write_coef(4'd12, 4'd5);
    exp_q.push_back(8'd0);
    send(fill(8'd10, 8'd20), 4'd0);
    wait_idle();
    exp_q.push_back(8'd255);
    send(fill(8'd255, 8'd0), 4'd0);
    wait_idle();

    // Enable dropped at MAC tap 5: abort with no output
    send(fill(8'd255, 8'd0), 4'd0);
    repeat (5) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_in_ready", {31'd0, in_ready}, 0);
    en = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("abort_no_valid", {31'd0, out_valid}, 0);

    // Asynchronous reset while holding a result in OUT
    out_ready = 1'b0;
    send(fill(8'd255, 8'd0), 4'd0);
    wait_valid();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 0);
    check("async_rst_busy", {31'd0, busy}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(8'd100);
    send(fill(8'd100, 8'd100), 4'd4);
    wait_idle();
    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
